// File: rtl/periph_slave_rr_arbiter_if.sv
// Bus bundle between N requesters, the per-slave arbiter and one peripheral target port.
// The slave modport is the arbiter's view; master is the surrounding crossbar/requester view.
interface periph_slave_rr_arbiter_if #(
  parameter int N_MASTER   = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = N_MASTER
);
  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][5:0]            data_atop_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;

  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_add_o;
  logic                  data_wen_o;
  logic [5:0]            data_atop_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic [BE_WIDTH-1:0]   data_be_o;
  logic [ID_WIDTH-1:0]   data_ID_o;
  logic                  data_gnt_i;
  logic                  data_r_valid_i;
  logic [ID_WIDTH-1:0]   data_r_ID_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_atop_i, data_wdata_i, data_be_i,
    input  data_gnt_i, data_r_valid_i, data_r_ID_i,
    output data_gnt_o, data_r_valid_o,
    output data_req_o, data_add_o, data_wen_o, data_atop_o, data_wdata_o, data_be_o, data_ID_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_atop_i, data_wdata_i, data_be_i,
    output data_gnt_i, data_r_valid_i, data_r_ID_i,
    input  data_gnt_o, data_r_valid_o,
    input  data_req_o, data_add_o, data_wen_o, data_atop_o, data_wdata_o, data_be_o, data_ID_o
  );
endinterface

// File: rtl/periph_slave_rr_arbiter.sv
// Round-robin arbiter in front of one peripheral slave port: locks the winner across
// target back-pressure, tags requests with a one-hot ID and throttles on outstanding count.
//
// state     | meaning
// ST_ARB    | round-robin search from ptr each cycle
// ST_LOCKED | winner held in lock_q until the target grants it
module periph_slave_rr_arbiter #(
  parameter int N_MASTER        = 16,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  periph_slave_rr_arbiter_if.slave bus,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     proto_err_o
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, lock_q, lock_d, rr_idx, sel_idx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                cand_req, throttled, fwd_req, hs, rid_onehot;
  logic [ID_WIDTH-1:0] rid;

  // Scan downward so the last hit is the one closest to p, wrapping mod N_MASTER.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTER-1:0] req,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] j;
    pick = p;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      j = IDX_W'((int'(p) + i) % N_MASTER);
      if (req[j]) pick = j;
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] idx);
    if (N_MASTER == 1 || idx == IDX_W'(N_MASTER - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  always_comb begin : select
    rr_idx     = rr_pick(bus.data_req_i, ptr_q);
    sel_idx    = (state_q == ST_LOCKED) ? lock_q : rr_idx;
    cand_req   = (state_q == ST_LOCKED) ? bus.data_req_i[lock_q] : |bus.data_req_i;
    throttled  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    fwd_req    = rst_n & cand_req & ~throttled;
    hs         = fwd_req & bus.data_gnt_i;
    rid        = bus.data_r_ID_i;
    rid_onehot = (rid != '0) && ((rid & (rid - ID_WIDTH'(1))) == '0);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_ARB: begin
        if (hs) begin
          ptr_d = inc_mod(sel_idx);
        end else if (fwd_req) begin
          lock_d  = sel_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // A throttled lock simply waits; only a dropped request breaks it without a grant.
        if (hs) begin
          ptr_d   = inc_mod(lock_q);
          state_d = ST_ARB;
        end else if (!bus.data_req_i[lock_q]) begin
          err_d   = 1'b1;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (hs && !bus.data_r_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!hs && bus.data_r_valid_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (bus.data_r_valid_i && (cnt_q == '0 || !rid_onehot)) err_d = 1'b1;
  end

  always_comb begin : outputs
    bus.data_req_o     = fwd_req;
    bus.data_gnt_o     = hs ? (N_MASTER'(1) << sel_idx) : '0;
    bus.data_ID_o      = fwd_req ? (ID_WIDTH'(1) << sel_idx) : '0;
    bus.data_add_o     = fwd_req ? bus.data_add_i[sel_idx] : '0;
    bus.data_wen_o     = fwd_req ? bus.data_wen_i[sel_idx] : 1'b0;
    bus.data_atop_o    = fwd_req ? bus.data_atop_i[sel_idx] : '0;
    bus.data_wdata_o   = fwd_req ? bus.data_wdata_i[sel_idx] : '0;
    bus.data_be_o      = fwd_req ? bus.data_be_i[sel_idx] : '0;
    bus.data_r_valid_o = {N_MASTER{rst_n & bus.data_r_valid_i}} & rid[N_MASTER-1:0];
  end

  assign outstanding_o = cnt_q;
  assign proto_err_o   = err_q;

endmodule

// File: tb/tb_periph_slave_rr_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a behavioural model
// of round-robin arbitration, locking, outstanding counting and error flagging.
module tb_periph_slave_rr_arbiter;
  localparam int N    = 4;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int IW   = N;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);
  localparam int XW   = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] outstanding;
  logic          proto_err;

  always #5 clk = ~clk;

  periph_slave_rr_arbiter_if #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                               .BE_WIDTH(BW), .ID_WIDTH(IW)) bus ();

  periph_slave_rr_arbiter #(.N_MASTER(N), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .outstanding_o(outstanding),
    .proto_err_o  (proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_ptr = 0, m_lock = 0, m_cnt = 0;
  bit m_locked = 1'b0, m_err = 1'b0;

  logic [N-1:0]  e_gnt;
  logic [N-1:0]  o_gnt, o_id, o_rv;
  logic          o_req;
  logic [AW-1:0] o_add;
  logic [CW-1:0] o_cnt;
  logic [N-1:0]  pending;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int k);
    return v[XW'(k)];
  endfunction

  function automatic int first_from(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++)
      if (bit_at(req, (start + i) % N)) return (start + i) % N;
    return -1;
  endfunction

  task automatic randomize_payload(input int k);
    bus.data_add_i[XW'(k)]   = AW'($urandom);
    bus.data_wen_i[XW'(k)]   = 1'($urandom);
    bus.data_atop_i[XW'(k)]  = 6'($urandom);
    bus.data_wdata_i[XW'(k)] = $urandom;
    bus.data_be_i[XW'(k)]    = BW'($urandom);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    int w;
    bit fwd, hs, rv;
    logic [N-1:0] req, rid;
    #1;
    req = bus.data_req_i;
    rv  = bus.data_r_valid_i;
    rid = bus.data_r_ID_i;
    if (m_locked) begin
      w   = m_lock;
      fwd = bit_at(req, w);
    end else begin
      w   = first_from(req, m_ptr);
      fwd = (w >= 0);
      if (w < 0) w = 0;
    end
    fwd   = fwd && rst_n && (m_cnt < MAXO);
    hs    = fwd && bus.data_gnt_i;
    e_gnt = hs ? (N'(1) << w) : '0;

    chk("req_o",     64'(bus.data_req_o),     64'(fwd));
    chk("gnt_o",     64'(bus.data_gnt_o),     64'(e_gnt));
    chk("id_o",      64'(bus.data_ID_o),      fwd ? 64'(1) << w : 64'(0));
    chk("add_o",     64'(bus.data_add_o),     fwd ? 64'(bus.data_add_i[XW'(w)]) : 64'(0));
    chk("wen_o",     64'(bus.data_wen_o),     fwd ? 64'(bus.data_wen_i[XW'(w)]) : 64'(0));
    chk("atop_o",    64'(bus.data_atop_o),    fwd ? 64'(bus.data_atop_i[XW'(w)]) : 64'(0));
    chk("wdata_o",   64'(bus.data_wdata_o),   fwd ? 64'(bus.data_wdata_i[XW'(w)]) : 64'(0));
    chk("be_o",      64'(bus.data_be_o),      fwd ? 64'(bus.data_be_i[XW'(w)]) : 64'(0));
    chk("r_valid_o", 64'(bus.data_r_valid_o), (rst_n && rv) ? 64'(rid) : 64'(0));

    o_gnt = bus.data_gnt_o;
    o_id  = bus.data_ID_o;
    o_rv  = bus.data_r_valid_o;
    o_req = bus.data_req_o;
    o_add = bus.data_add_o;
    o_cnt = outstanding;

    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_lock = 0; m_cnt = 0; m_locked = 1'b0; m_err = 1'b0;
    end else begin
      if (m_locked) begin
        if (hs) begin
          m_ptr = (m_lock + 1) % N;
          m_locked = 1'b0;
        end else if (!bit_at(req, m_lock)) begin
          m_err = 1'b1;
          m_locked = 1'b0;
        end
      end else if (hs) begin
        m_ptr = (w + 1) % N;
      end else if (fwd) begin
        m_locked = 1'b1;
        m_lock = w;
      end
      if (rv && (m_cnt == 0 || $countones(rid) != 1)) m_err = 1'b1;
      if (hs && !rv) m_cnt = m_cnt + 1;
      else if (rv && !hs && m_cnt > 0) m_cnt = m_cnt - 1;
    end
    #1;
    chk("outstanding", 64'(outstanding), 64'(m_cnt));
    chk("proto_err",   64'(proto_err),   64'(m_err));
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.data_req_i     = '0;
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
    bus.data_r_ID_i    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] fair_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int k = 0; k < N; k++) randomize_payload(k);
    set_idle();
    pending = '0;
    @(negedge clk);

    // reset state with active-looking inputs: everything masked
    bus.data_req_i = 4'hF; bus.data_gnt_i = 1'b1; bus.data_r_valid_i = 1'b1; bus.data_r_ID_i = 4'h2;
    do_reset();
    chk("rst_req", 64'(o_req), 64'(0));
    chk("rst_rv",  64'(o_rv),  64'(0));
    set_idle();

    // fairness: all request, target always grants, responses keep count low
    do_reset();
    bus.data_req_i = 4'hF; bus.data_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_r_valid_i = (i > 0);
      bus.data_r_ID_i    = (i > 0) ? (N'(1) << ((i - 1) % N)) : '0;
      run_cycle();
      chk("fair_id",  64'(o_id),  64'(fair_exp[i]));
      chk("fair_gnt", 64'(o_gnt), 64'(fair_exp[i]));
    end
    set_idle();

    // lock across back-pressure
    do_reset();
    bus.data_req_i = 4'b0110;
    bus.data_add_i[1] = 30'h1234567;
    for (int i = 0; i < 3; i++) begin
      randomize_payload(2);
      run_cycle();
      chk("lock_id",  64'(o_id),  64'(4'h2));
      chk("lock_add", 64'(o_add), 64'(30'h1234567));
    end
    bus.data_gnt_i = 1'b1;
    run_cycle();
    chk("lock_gnt", 64'(o_gnt), 64'(4'h2));
    run_cycle();
    chk("lock_next", 64'(o_id), 64'(4'h4));
    set_idle();

    // throttle at MAX_OUTSTANDING
    do_reset();
    bus.data_req_i = 4'hF; bus.data_gnt_i = 1'b1;
    repeat (4) run_cycle();
    chk("thr_cnt", 64'(outstanding), 64'(4));
    run_cycle();
    chk("thr_req", 64'(o_req), 64'(0));
    chk("thr_gnt", 64'(o_gnt), 64'(0));
    bus.data_r_valid_i = 1'b1; bus.data_r_ID_i = 4'h1;
    run_cycle();
    bus.data_r_valid_i = 1'b0;
    run_cycle();
    chk("thr_drop_cnt", 64'(o_cnt), 64'(3));
    chk("thr_drop_req", 64'(o_req), 64'(1));
    set_idle();

    // handshake and response in the same cycle
    do_reset();
    bus.data_req_i = 4'hF; bus.data_gnt_i = 1'b1;
    repeat (2) run_cycle();
    bus.data_r_valid_i = 1'b1; bus.data_r_ID_i = 4'h1;
    run_cycle();
    chk("simul_cnt", 64'(outstanding), 64'(2));

    // response routing then a non-one-hot ID
    bus.data_req_i = '0; bus.data_gnt_i = 1'b0;
    bus.data_r_ID_i = 4'h8;
    run_cycle();
    chk("route_rv",  64'(o_rv),      64'(4'h8));
    chk("route_err", 64'(proto_err), 64'(0));
    bus.data_r_ID_i = 4'h9;
    run_cycle();
    chk("badid_err", 64'(proto_err), 64'(1));
    chk("badid_rv",  64'(o_rv),      64'(4'h9));
    set_idle();

    // response with nothing outstanding
    do_reset();
    bus.data_r_valid_i = 1'b1; bus.data_r_ID_i = 4'h1;
    run_cycle();
    chk("zero_err", 64'(proto_err),   64'(1));
    chk("zero_cnt", 64'(outstanding), 64'(0));
    set_idle();

    // locked master drops its request
    do_reset();
    bus.data_req_i = 4'b0010;
    run_cycle();
    bus.data_req_i = 4'b0000;
    run_cycle();
    chk("drop_err", 64'(proto_err), 64'(1));
    bus.data_req_i = 4'b0100;
    run_cycle();
    chk("drop_arb_req", 64'(o_req), 64'(1));
    chk("drop_arb_id",  64'(o_id),  64'(4'h4));
    do_reset();
    chk("rst_err", 64'(proto_err),   64'(0));
    chk("rst_cnt", 64'(outstanding), 64'(0));

    // randomized traffic; every fourth block allows protocol abuse
    for (int blk = 0; blk < 30; blk++) begin
      bit errmode;
      errmode = (blk % 4 == 3);
      bus.data_req_i     = N'($urandom);
      bus.data_gnt_i     = 1'($urandom);
      bus.data_r_valid_i = 1'($urandom);
      bus.data_r_ID_i    = IW'($urandom);
      pending = '0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
        for (int k = 0; k < N; k++) begin
          if (!pending[XW'(k)]) begin
            randomize_payload(k);
            if ($urandom_range(0, 99) < 35) pending[XW'(k)] = 1'b1;
          end else if (errmode && $urandom_range(0, 99) < 10) begin
            pending[XW'(k)] = 1'b0;
          end
        end
        bus.data_req_i = pending;
        bus.data_gnt_i = ($urandom_range(0, 99) < 60);
        if (errmode) begin
          bus.data_r_valid_i = ($urandom_range(0, 99) < 40);
          bus.data_r_ID_i    = IW'($urandom);
        end else begin
          bus.data_r_valid_i = (m_cnt > 0) && ($urandom_range(0, 99) < 40);
          bus.data_r_ID_i    = IW'(1) << $urandom_range(0, N - 1);
        end
        run_cycle();
        pending = pending & ~e_gnt;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/periph_slave_rr_arbiter.md
Name: periph_slave_rr_arbiter

Overview:
Per-slave request arbiter and sequencer for the peripheral crossbar. It shares one peripheral target port between N_MASTER requesters using round-robin priority, and holds the winning request stable across target back-pressure. It also tags each request with a one-hot master ID and routes target responses back by that ID. A bounded outstanding-transaction counter throttles requests and flags protocol errors. One instance sits in front of each peripheral slave port.

Parameters:
N_MASTER, 16, number of requesters
ADDR_WIDTH, 30, word-address width forwarded to target
DATA_WIDTH, 32, write data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
ID_WIDTH, N_MASTER, one-hot ID width
MAX_OUTSTANDING, 4, max accepted-but-unanswered transactions (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_req_i  in  N_MASTER  per-master request
data_add_i  in  N_MASTER x ADDR_WIDTH  address
data_wen_i  in  N_MASTER  1=load, 0=store
data_atop_i  in  N_MASTER x 6  atomic op
data_wdata_i  in  N_MASTER x DATA_WIDTH  write data
data_be_i  in  N_MASTER x BE_WIDTH  byte enable
data_gnt_o  out  N_MASTER  per-master grant
data_r_valid_o  out  N_MASTER  per-master response valid
data_req_o  out  1  request to target
data_add_o / data_wen_o / data_atop_o / data_wdata_o / data_be_o  out  as inputs  muxed payload
data_ID_o  out  ID_WIDTH  one-hot ID of the forwarded master
data_gnt_i  in  1  target grant
data_r_valid_i  in  1  target response valid
data_r_ID_i  in  ID_WIDTH  response ID
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: ptr=0, state=ARB, lock_idx=0, outstanding=0, proto_err_o=0.
  - Combinational outputs are 0 during reset, because the accept path is masked by !rst_n.
- Request path latency: 0 cycles (combinational req/payload/grant).
- Handshake: a transfer (hs) occurs when data_req_o & data_gnt_i.
  - data_gnt_o[w] = hs for the selected master w; all other bits are 0.
- Payload rules:
  - data_ID_o = 1<<w while data_req_o=1, else 0.
  - Payload outputs are 0 when data_req_o=0.
- Throttle: when outstanding==MAX_OUTSTANDING, data_req_o=0 and all data_gnt_o=0. The ARB/LOCKED state is unaffected.
- State ARB:
  - w = first index with data_req_i high, searching ptr, ptr+1, ... wrapping mod N_MASTER.
  - data_req_o = |data_req_i.
  - On hs: ptr <= (w+1) mod N_MASTER; stay in ARB.
  - If data_req_o & !data_gnt_i: lock_idx <= w, go to LOCKED.
- State LOCKED:
  - w = lock_idx and data_req_o = data_req_i[lock_idx]; no re-arbitration.
  - On hs: ptr <= (lock_idx+1) mod N_MASTER, go to ARB.
  - If data_req_i[lock_idx] drops before hs: set proto_err_o, go to ARB, ptr unchanged.
  - If throttled while locked: remain LOCKED.
- Outstanding counter:
  - +1 on hs; -1 on data_r_valid_i; unchanged if both occur in the same cycle.
  - data_r_valid_i with outstanding==0: count stays 0 and proto_err_o is set.
- Response path (combinational): data_r_valid_o[k] = data_r_valid_i & data_r_ID_i[k].
  - data_r_valid_i with data_r_ID_i not one-hot: set proto_err_o; forward bits unchanged.
- proto_err_o clears only on reset.
- Reset mid-operation: LOCKED is abandoned and the counter is cleared. Responses already in flight after reset do not decrement below 0 and flag an error.
- N_MASTER=1: ptr is constant 0; arbitration degenerates to pass-through.

Test Plan:
- Fairness: N=4, masters 0..3 requesting continuously, gnt_i=1 -> grants in order 0,1,2,3,0; data_ID_o = 1,2,4,8,1.
- Lock: masters 1 and 2 request, ptr=0, gnt_i=0 for 3 cycles -> data_ID_o stays 0x2 with payload stable. Then gnt_i=1 -> data_gnt_o=0x2, next winner is master 2.
- Throttle: MAX_OUTSTANDING=4, 4 accepted with no responses -> outstanding_o=4, data_req_o=0. One r_valid_i -> outstanding_o=3, the next request is forwarded in the same cycle as the count drop.
- Simultaneous: hs and r_valid_i in the same cycle with outstanding=2 -> outstanding stays 2.
- Response routing: r_valid_i=1, r_ID_i=0x0008 -> data_r_valid_o=0x0008. Then r_ID_i=0x0009 -> proto_err_o=1.
- Errors/reset: r_valid_i with outstanding=0 -> proto_err_o=1, count 0. LOCKED master drops req -> proto_err_o=1, state ARB. Then rst_n=0 for 1 cycle -> all flags and counters 0.
